// File: rtl/msrv32_decode_stage.sv
// ---------------------------------------------------------------------------
// msrv32_decode_stage
//
// Registered RV32I decode stage between fetch and execute. Each accepted
// instruction is decoded combinationally, and the decoded control bundle is
// written into a small FIFO. Execute reads the head entry. Fetch and execute
// can therefore stall independently. A trap flush empties the FIFO. A
// saturating counter records accepted illegal instructions.
//
// Optional feature macro: MSRV32_DEC_MEXT_EN
//   defined   : OP with funct7=0000001 (M extension) is legal, is_muldiv_out=1
//   undefined : funct7=0000001 is illegal, is_muldiv_out tied 0
//
// Handshake (valid/ready):
//   - Accept:  in_valid_in & in_ready_out, where in_ready_out = !full. Ready
//     never looks at out_ready_in, so a full FIFO cannot pass data through
//     in the same cycle.
//   - Pop:     out_valid_out & out_ready_in, where out_valid_out = !empty.
//   - A push and a pop may share a cycle. A trap flush overrides both, and
//     the input offered in the flush cycle is dropped.
//
// Ports:
//   clk_in, rst_in             clock, synchronous active-high reset
//   in_valid_in/in_ready_out   upstream handshake
//   instr_in, pc_in            instruction word and its PC
//   iadder_out_1_to_0_in       effective-address low bits (load/store)
//   trap_taken_in              flush request
//   out_valid_out/out_ready_in downstream handshake
//   instr_out, pc_out ...      head entry: instruction, PC, decoded controls,
//                              exception flags (all zero while empty)
//   illegal_count_out          saturating count of accepted illegal instrs
// ---------------------------------------------------------------------------
module msrv32_decode_stage #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 2,
  parameter int ILL_CNT_W = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 in_valid_in,
  output logic                 in_ready_out,
  input  logic [31:0]          instr_in,
  input  logic [XLEN-1:0]      pc_in,
  input  logic [1:0]           iadder_out_1_to_0_in,
  input  logic                 trap_taken_in,
  output logic                 out_valid_out,
  input  logic                 out_ready_in,
  output logic [31:0]          instr_out,
  output logic [XLEN-1:0]      pc_out,
  output logic [2:0]           wb_mux_sel_out,
  output logic [2:0]           imm_type_out,
  output logic [2:0]           csr_op_out,
  output logic [3:0]           alu_opcode_out,
  output logic [1:0]           load_size_out,
  output logic                 load_unsigned_out,
  output logic                 mem_wr_req_out,
  output logic                 alu_src_out,
  output logic                 iadder_src_out,
  output logic                 csr_wr_en_out,
  output logic                 rf_wr_en_out,
  output logic                 illegal_instr_out,
  output logic                 misaligned_load_out,
  output logic                 misaligned_store_out,
  output logic                 is_muldiv_out,
  output logic [ILL_CNT_W-1:0] illegal_count_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // opcode[6:2] classes
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [2:0]      wb_mux_sel;
    logic [2:0]      imm_type;
    logic [2:0]      csr_op;
    logic [3:0]      alu_opcode;
    logic [1:0]      load_size;
    logic            load_unsigned;
    logic            mem_wr_req;
    logic            alu_src;
    logic            iadder_src;
    logic            csr_wr_en;
    logic            rf_wr_en;
    logic            illegal;
    logic            mis_load;
    logic            mis_store;
    logic            is_muldiv;
  } entry_t;

  // -------------------------------------------------------------------------
  // Field extraction and class flags
  // -------------------------------------------------------------------------
  logic [4:0] w_opc;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_rd;

  assign w_opc    = instr_in[6:2];
  assign w_funct3 = instr_in[14:12];
  assign w_funct7 = instr_in[31:25];
  assign w_rd     = instr_in[11:7];

  logic w_is_branch, w_is_jal, w_is_jalr, w_is_auipc, w_is_lui, w_is_op;
  logic w_is_op_imm, w_is_load, w_is_store, w_is_system, w_is_misc_mem;
  logic w_is_csr, w_known;

  assign w_is_branch   = (w_opc == OPC_BRANCH);
  assign w_is_jal      = (w_opc == OPC_JAL);
  assign w_is_jalr     = (w_opc == OPC_JALR);
  assign w_is_auipc    = (w_opc == OPC_AUIPC);
  assign w_is_lui      = (w_opc == OPC_LUI);
  assign w_is_op       = (w_opc == OPC_OP);
  assign w_is_op_imm   = (w_opc == OPC_OP_IMM);
  assign w_is_load     = (w_opc == OPC_LOAD);
  assign w_is_store    = (w_opc == OPC_STORE);
  assign w_is_system   = (w_opc == OPC_SYSTEM);
  assign w_is_misc_mem = (w_opc == OPC_MISC_MEM);
  // funct3 == 000 in SYSTEM is ECALL/EBREAK/xRET: no CSR access
  assign w_is_csr      = w_is_system & (w_funct3 != 3'b000);
  assign w_known       = w_is_branch | w_is_jal | w_is_jalr | w_is_auipc |
                         w_is_lui | w_is_op | w_is_op_imm | w_is_load |
                         w_is_store | w_is_system | w_is_misc_mem;

  // -------------------------------------------------------------------------
  // Legality
  // -------------------------------------------------------------------------
  logic w_muldiv;
  logic w_op_f7_ok;
  logic w_shift_bad;
  logic w_load_bad;
  logic w_store_bad;
  logic w_illegal;

`ifdef MSRV32_DEC_MEXT_EN
  assign w_muldiv   = w_is_op & (w_funct7 == 7'b0000001);
`else
  assign w_muldiv   = 1'b0;
`endif

  assign w_op_f7_ok = (w_funct7 == 7'b0000000) | (w_funct7 == 7'b0100000) |
                      w_muldiv;

  // SLLI takes only funct7=0; SRLI/SRAI take 0 or 0100000
  assign w_shift_bad = w_is_op_imm &
                       (((w_funct3 == 3'b001) & (w_funct7 != 7'b0000000)) |
                        ((w_funct3 == 3'b101) & (w_funct7 != 7'b0000000) &
                         (w_funct7 != 7'b0100000)));

  assign w_load_bad  = w_is_load & ((w_funct3 == 3'b011) |
                                    (w_funct3 == 3'b110) |
                                    (w_funct3 == 3'b111));
  assign w_store_bad = w_is_store & (w_funct3 >= 3'b011);

  assign w_illegal = (instr_in[1:0] != 2'b11) | ~w_known |
                     (w_is_op & ~w_op_f7_ok) | w_shift_bad |
                     w_load_bad | w_store_bad;

  // -------------------------------------------------------------------------
  // Alignment: halfword needs addr[0]==0, word needs addr==00
  // -------------------------------------------------------------------------
  logic w_misaligned;
  assign w_misaligned = ((w_funct3[1:0] == 2'b01) & iadder_out_1_to_0_in[0]) |
                        ((w_funct3[1:0] == 2'b10) &
                         (iadder_out_1_to_0_in != 2'b00));

  // -------------------------------------------------------------------------
  // Control decode into an entry
  // -------------------------------------------------------------------------
  entry_t w_dec;

  always_comb begin
    w_dec       = '0;
    w_dec.instr = instr_in;
    w_dec.pc    = pc_in;

    if (w_is_jal) begin
      w_dec.wb_mux_sel = 3'b101;
      w_dec.imm_type   = 3'b101;
    end else if (w_is_jalr) begin
      w_dec.wb_mux_sel = 3'b101;
      w_dec.imm_type   = 3'b001;
      w_dec.iadder_src = 1'b1;
    end else if (w_is_branch) begin
      w_dec.imm_type   = 3'b011;
    end else if (w_is_auipc) begin
      w_dec.wb_mux_sel = 3'b011;
      w_dec.imm_type   = 3'b100;
    end else if (w_is_lui) begin
      w_dec.wb_mux_sel = 3'b010;
      w_dec.imm_type   = 3'b100;
    end else if (w_is_op) begin
      w_dec.alu_src    = 1'b1;
    end else if (w_is_op_imm) begin
      w_dec.imm_type   = 3'b001;
    end else if (w_is_load) begin
      w_dec.wb_mux_sel = 3'b001;
      w_dec.imm_type   = 3'b001;
      w_dec.iadder_src = 1'b1;
    end else if (w_is_store) begin
      w_dec.imm_type   = 3'b010;
      w_dec.iadder_src = 1'b1;
    end else if (w_is_csr) begin
      w_dec.wb_mux_sel = 3'b100;
      w_dec.imm_type   = 3'b110;
    end

    // funct7[5] selects SUB/SRA; for immediates only SRAI carries it
    if (w_muldiv) begin
      w_dec.alu_opcode = {1'b0, w_funct3};
    end else if (w_is_op | w_is_op_imm) begin
      w_dec.alu_opcode = {w_funct7[5] & (w_is_op | (w_funct3 == 3'b101)),
                          w_funct3};
    end

    w_dec.csr_op        = w_is_csr ? w_funct3 : 3'b000;
    w_dec.load_size     = w_is_load ? w_funct3[1:0] : 2'b00;
    w_dec.load_unsigned = w_is_load & w_funct3[2];
    w_dec.mis_load      = w_is_load & w_misaligned;
    w_dec.mis_store     = w_is_store & w_misaligned;
    w_dec.illegal       = w_illegal;
    w_dec.is_muldiv     = w_muldiv;
    w_dec.mem_wr_req    = w_is_store & ~w_illegal & ~w_dec.mis_store;
    w_dec.csr_wr_en     = w_is_csr & ~w_illegal;
    w_dec.rf_wr_en      = (w_is_lui | w_is_auipc | w_is_jal | w_is_jalr |
                           w_is_op | w_is_op_imm | w_is_load | w_is_csr) &
                          (w_rd != 5'd0) & ~w_illegal;
  end

  // -------------------------------------------------------------------------
  // FIFO: pointers carry one extra wrap bit to tell full from empty
  // -------------------------------------------------------------------------
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  entry_t               r_mem [DEPTH];
  logic [ILL_CNT_W-1:0] r_ill_cnt;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign in_ready_out  = ~w_full;
  assign out_valid_out = ~w_empty;

  assign w_push = in_valid_in & ~w_full & ~trap_taken_in;
  assign w_pop  = ~w_empty & out_ready_in & ~trap_taken_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ill_cnt <= '0;
    end else if (trap_taken_in) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push & w_illegal & ~(&r_ill_cnt)) r_ill_cnt <= r_ill_cnt + 1'b1;
    end
  end

  // Payload storage needs no reset: it is only visible while the slot is live
  always_ff @(posedge clk_in) begin
    if (w_push & ~rst_in) r_mem[r_wr_ptr[AW-1:0]] <= w_dec;
  end

  // -------------------------------------------------------------------------
  // Head entry, forced to zero while empty
  // -------------------------------------------------------------------------
  entry_t w_head;
  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  assign instr_out            = w_head.instr;
  assign pc_out               = w_head.pc;
  assign wb_mux_sel_out       = w_head.wb_mux_sel;
  assign imm_type_out         = w_head.imm_type;
  assign csr_op_out           = w_head.csr_op;
  assign alu_opcode_out       = w_head.alu_opcode;
  assign load_size_out        = w_head.load_size;
  assign load_unsigned_out    = w_head.load_unsigned;
  assign mem_wr_req_out       = w_head.mem_wr_req;
  assign alu_src_out          = w_head.alu_src;
  assign iadder_src_out       = w_head.iadder_src;
  assign csr_wr_en_out        = w_head.csr_wr_en;
  assign rf_wr_en_out         = w_head.rf_wr_en;
  assign illegal_instr_out    = w_head.illegal;
  assign misaligned_load_out  = w_head.mis_load;
  assign misaligned_store_out = w_head.mis_store;
  assign is_muldiv_out        = w_head.is_muldiv;
  assign illegal_count_out    = r_ill_cnt;

endmodule

// File: tb/tb_msrv32_decode_stage.sv
// Testbench for msrv32_decode_stage. A second instance with a 2-bit
// illegal counter shares all inputs and is used for the saturation case.
module tb_msrv32_decode_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic            rst_in;
  logic            in_valid_in;
  logic            in_ready_out;
  logic [31:0]     instr_in;
  logic [XLEN-1:0] pc_in;
  logic [1:0]      iadder_out_1_to_0_in;
  logic            trap_taken_in;
  logic            out_valid_out;
  logic            out_ready_in;
  logic [31:0]     instr_out;
  logic [XLEN-1:0] pc_out;
  logic [2:0]      wb_mux_sel_out, imm_type_out, csr_op_out;
  logic [3:0]      alu_opcode_out;
  logic [1:0]      load_size_out;
  logic            load_unsigned_out, mem_wr_req_out, alu_src_out;
  logic            iadder_src_out, csr_wr_en_out, rf_wr_en_out;
  logic            illegal_instr_out, misaligned_load_out, misaligned_store_out;
  logic            is_muldiv_out;
  logic [15:0]     illegal_count_out;

  // second instance outputs
  logic            b_in_ready, b_out_valid;
  logic [31:0]     b_instr;
  logic [XLEN-1:0] b_pc;
  logic [2:0]      b_wb, b_imm, b_csr_op;
  logic [3:0]      b_alu;
  logic [1:0]      b_ld_size;
  logic            b_ld_uns, b_mem_wr, b_alu_src, b_iadd_src, b_csr_wr, b_rf_wr;
  logic            b_ill, b_mis_ld, b_mis_st, b_muldiv;
  logic [1:0]      b_count;

  msrv32_decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .ILL_CNT_W(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .in_valid_in(in_valid_in), .in_ready_out(in_ready_out),
    .instr_in(instr_in), .pc_in(pc_in),
    .iadder_out_1_to_0_in(iadder_out_1_to_0_in),
    .trap_taken_in(trap_taken_in),
    .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
    .instr_out(instr_out), .pc_out(pc_out),
    .wb_mux_sel_out(wb_mux_sel_out), .imm_type_out(imm_type_out),
    .csr_op_out(csr_op_out), .alu_opcode_out(alu_opcode_out),
    .load_size_out(load_size_out), .load_unsigned_out(load_unsigned_out),
    .mem_wr_req_out(mem_wr_req_out), .alu_src_out(alu_src_out),
    .iadder_src_out(iadder_src_out), .csr_wr_en_out(csr_wr_en_out),
    .rf_wr_en_out(rf_wr_en_out), .illegal_instr_out(illegal_instr_out),
    .misaligned_load_out(misaligned_load_out),
    .misaligned_store_out(misaligned_store_out),
    .is_muldiv_out(is_muldiv_out), .illegal_count_out(illegal_count_out)
  );

  msrv32_decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .ILL_CNT_W(2)) dut_sat (
    .clk_in(clk_in), .rst_in(rst_in),
    .in_valid_in(in_valid_in), .in_ready_out(b_in_ready),
    .instr_in(instr_in), .pc_in(pc_in),
    .iadder_out_1_to_0_in(iadder_out_1_to_0_in),
    .trap_taken_in(trap_taken_in),
    .out_valid_out(b_out_valid), .out_ready_in(out_ready_in),
    .instr_out(b_instr), .pc_out(b_pc),
    .wb_mux_sel_out(b_wb), .imm_type_out(b_imm),
    .csr_op_out(b_csr_op), .alu_opcode_out(b_alu),
    .load_size_out(b_ld_size), .load_unsigned_out(b_ld_uns),
    .mem_wr_req_out(b_mem_wr), .alu_src_out(b_alu_src),
    .iadder_src_out(b_iadd_src), .csr_wr_en_out(b_csr_wr),
    .rf_wr_en_out(b_rf_wr), .illegal_instr_out(b_ill),
    .misaligned_load_out(b_mis_ld), .misaligned_store_out(b_mis_st),
    .is_muldiv_out(b_muldiv), .illegal_count_out(b_count)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // {wb, imm, alu, alu_src, iadder_src, rf_wr, csr_wr, mem_wr, illegal, csr_op}
  function automatic logic [18:0] dec_vec();
    return {wb_mux_sel_out, imm_type_out, alu_opcode_out, alu_src_out,
            iadder_src_out, rf_wr_en_out, csr_wr_en_out, mem_wr_req_out,
            illegal_instr_out, csr_op_out};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [1:0] addr);
    in_valid_in          = v;
    instr_in             = ins;
    iadder_out_1_to_0_in = addr;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    drive(1'b0, 32'h0, 2'b00);
    trap_taken_in = 1'b0;
    out_ready_in  = 1'b0;
    step();
    step();
    rst_in = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total++; if (out_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid_out); end
    total++; if (in_ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", in_ready_out); end
    total++; if (illegal_count_out !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", illegal_count_out); end
    total++; if (dec_vec() !== 19'd0 || instr_out !== 32'd0) begin bad++; $display("FAIL reset_bundle: got %0h/%0h want 0/0", dec_vec(), instr_out); end
  endtask

  task automatic test_addi();
    do_reset();
    out_ready_in = 1'b1;
    pc_in = 32'h0000_0100;
    drive(1'b1, 32'h0050_0093, 2'b00);
    step();
    drive(1'b0, 32'h0, 2'b00);
    total++; if (out_valid_out !== 1'b1) begin bad++; $display("FAIL addi_valid: got %0b want 1", out_valid_out); end
    total++; if (dec_vec() !== 19'b000_001_0000_0_0_1_0_0_0_000) begin bad++; $display("FAIL addi_decode: got %0b want %0b", dec_vec(), 19'b000_001_0000_0_0_1_0_0_0_000); end
    total++; if (instr_out !== 32'h0050_0093 || pc_out !== 32'h100) begin bad++; $display("FAIL addi_payload: got %0h/%0h want 00500093/100", instr_out, pc_out); end
    step();
    total++; if (out_valid_out !== 1'b0) begin bad++; $display("FAIL addi_popped: got %0b want 0", out_valid_out); end
  endtask

  task automatic test_decode_table();
    logic [31:0] t_ins [19];
    logic [18:0] t_exp [19];
    t_ins = '{32'h0050_0093, 32'h4020_81B3, 32'h4030_D093, 32'h4000_0093,
              32'h4030_9093, 32'h1234_52B7, 32'h0000_1097, 32'h0080_00EF,
              32'h0000_8067, 32'h0020_8463, 32'h3001_10F3, 32'h0FF0_000F,
              32'h0000_B083, 32'h0020_B023, 32'h0020_A023, 32'h0000_0073,
              32'h0420_8033, 32'hFFFF_FFFF, 32'h0050_0091};
    t_exp = '{19'b000_001_0000_0_0_1_0_0_0_000,   // addi x1
              19'b000_000_1000_1_0_1_0_0_0_000,   // sub x3
              19'b000_001_1101_0_0_1_0_0_0_000,   // srai x1
              19'b000_001_0000_0_0_1_0_0_0_000,   // addi imm bit10 set
              19'b000_001_0001_0_0_0_0_0_1_000,   // slli bad funct7
              19'b010_100_0000_0_0_1_0_0_0_000,   // lui x5
              19'b011_100_0000_0_0_1_0_0_0_000,   // auipc x1
              19'b101_101_0000_0_0_1_0_0_0_000,   // jal x1
              19'b101_001_0000_0_1_0_0_0_0_000,   // jalr x0
              19'b000_011_0000_0_0_0_0_0_0_000,   // beq
              19'b100_110_0000_0_0_1_1_0_0_001,   // csrrw x1
              19'b000_000_0000_0_0_0_0_0_0_000,   // fence
              19'b001_001_0000_0_1_0_0_0_1_000,   // ld (illegal)
              19'b000_010_0000_0_1_0_0_0_1_000,   // sd (illegal)
              19'b000_010_0000_0_1_0_0_1_0_000,   // sw
              19'b000_000_0000_0_0_0_0_0_0_000,   // ecall
              19'b000_000_0000_1_0_0_0_0_1_000,   // op funct7=0000010
              19'b000_000_0000_0_0_0_0_0_1_000,   // all ones
              19'b000_001_0000_0_0_0_0_0_1_000};  // low bits 01
    do_reset();
    out_ready_in = 1'b1;
    for (int i = 0; i < 19; i++) begin
      drive(1'b1, t_ins[i], 2'b00);
      step();
      total++;
      if (out_valid_out !== 1'b1 || instr_out !== t_ins[i] || dec_vec() !== t_exp[i]) begin
        bad++;
        $display("FAIL decode_%0d: got v=%0b ins=%0h dec=%0b want v=1 ins=%0h dec=%0b",
                 i, out_valid_out, instr_out, dec_vec(), t_ins[i], t_exp[i]);
      end
    end
    drive(1'b0, 32'h0, 2'b00);
    total++; if (illegal_count_out !== 16'd6) begin bad++; $display("FAIL decode_ill_count: got %0d want 6", illegal_count_out); end
    step();
    total++; if (out_valid_out !== 1'b0 || dec_vec() !== 19'd0) begin bad++; $display("FAIL decode_empty_zero: got v=%0b dec=%0b want 0/0", out_valid_out, dec_vec()); end
  endtask

  // one cycle of the ordering scoreboard: check head against the model,
  // then apply the handshake to the model and advance the clock
  task automatic bb_cycle(input logic v, input logic [31:0] ins, input logic rdy,
                          inout int cnt);
    logic acc;
    logic pop;
    drive(v, ins, 2'b00);
    out_ready_in = rdy;
    total++; if (in_ready_out !== (cnt < DEPTH)) begin bad++; $display("FAIL bb_ready: got %0b want %0b (occ %0d)", in_ready_out, (cnt < DEPTH), cnt); end
    total++; if (out_valid_out !== (cnt > 0)) begin bad++; $display("FAIL bb_valid: got %0b want %0b (occ %0d)", out_valid_out, (cnt > 0), cnt); end
    if (cnt > 0) begin
      total++; if (instr_out !== exp_q[0]) begin bad++; $display("FAIL bb_order: got %0h want %0h", instr_out, exp_q[0]); end
    end
    pop = rdy && (cnt > 0);
    acc = v && (cnt < DEPTH);
    if (pop) begin void'(exp_q.pop_front()); cnt--; end
    if (acc) begin exp_q.push_back(ins); cnt++; end
    step();
  endtask

  task automatic test_back_to_back();
    int cnt;
    cnt = 0;
    exp_q.delete();
    do_reset();
    bb_cycle(1'b1, 32'h0050_0093, 1'b0, cnt);
    bb_cycle(1'b1, 32'h00A0_0113, 1'b0, cnt);
    bb_cycle(1'b1, 32'h00F0_0193, 1'b0, cnt);  // full: not accepted
    bb_cycle(1'b1, 32'h00F0_0193, 1'b1, cnt);  // pop only at full
    bb_cycle(1'b1, 32'h00F0_0193, 1'b1, cnt);  // push + pop
    bb_cycle(1'b1, 32'h0140_0213, 1'b1, cnt);
    bb_cycle(1'b1, 32'h0190_0293, 1'b1, cnt);
    bb_cycle(1'b0, 32'h0, 1'b1, cnt);
    bb_cycle(1'b0, 32'h0, 1'b0, cnt);
    total++; if (out_valid_out !== 1'b0) begin bad++; $display("FAIL bb_drained: got %0b want 0", out_valid_out); end
  endtask

  task automatic test_misaligned();
    do_reset();
    out_ready_in = 1'b1;
    drive(1'b1, 32'h0000_A083, 2'b10);  // lw, addr 10
    step();
    total++; if ({misaligned_load_out, load_size_out, load_unsigned_out, wb_mux_sel_out} !== 7'b1_10_0_001) begin bad++; $display("FAIL lw_mis: got %0b want 1100001", {misaligned_load_out, load_size_out, load_unsigned_out, wb_mux_sel_out}); end
    drive(1'b1, 32'h0020_9023, 2'b01);  // sh, addr 01
    step();
    total++; if ({misaligned_store_out, mem_wr_req_out, misaligned_load_out} !== 3'b100) begin bad++; $display("FAIL sh_mis: got %0b want 100", {misaligned_store_out, mem_wr_req_out, misaligned_load_out}); end
    drive(1'b1, 32'h0020_A023, 2'b00);  // sw, aligned
    step();
    total++; if ({misaligned_store_out, mem_wr_req_out} !== 2'b01) begin bad++; $display("FAIL sw_aligned: got %0b want 01", {misaligned_store_out, mem_wr_req_out}); end
    drive(1'b1, 32'h0000_C083, 2'b11);  // lbu, any address fine
    step();
    total++; if ({misaligned_load_out, load_size_out, load_unsigned_out} !== 4'b0_00_1) begin bad++; $display("FAIL lbu: got %0b want 0001", {misaligned_load_out, load_size_out, load_unsigned_out}); end
    drive(1'b1, 32'h0000_9083, 2'b10);  // lh, addr 10 aligned
    step();
    total++; if ({misaligned_load_out, load_size_out} !== 3'b0_01) begin bad++; $display("FAIL lh_aligned: got %0b want 001", {misaligned_load_out, load_size_out}); end
    drive(1'b1, 32'h0000_9083, 2'b11);  // lh, addr 11
    step();
    total++; if (misaligned_load_out !== 1'b1) begin bad++; $display("FAIL lh_mis: got %0b want 1", misaligned_load_out); end
    drive(1'b0, 32'h0, 2'b00);
    step();
  endtask

  task automatic test_flush();
    do_reset();
    out_ready_in = 1'b0;
    drive(1'b1, 32'h0050_0093, 2'b00);
    step();
    drive(1'b1, 32'h00A0_0113, 2'b00);
    step();
    drive(1'b1, 32'hFFFF_FFFF, 2'b00);  // illegal, offered in flush cycle
    trap_taken_in = 1'b1;
    #1;
    total++; if (in_ready_out !== 1'b0) begin bad++; $display("FAIL flush_ready_cycle: got %0b want 0", in_ready_out); end
    step();
    trap_taken_in = 1'b0;
    drive(1'b0, 32'h0, 2'b00);
    total++; if (out_valid_out !== 1'b0 || in_ready_out !== 1'b1) begin bad++; $display("FAIL flush_empty: got v=%0b r=%0b want 0/1", out_valid_out, in_ready_out); end
    total++; if (illegal_count_out !== 16'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", illegal_count_out); end
    out_ready_in = 1'b1;
    step();
    step();
    total++; if (out_valid_out !== 1'b0) begin bad++; $display("FAIL flush_nothing_later: got %0b want 0", out_valid_out); end
    drive(1'b1, 32'h00F0_0193, 2'b00);
    step();
    drive(1'b0, 32'h0, 2'b00);
    total++; if (out_valid_out !== 1'b1 || instr_out !== 32'h00F0_0193) begin bad++; $display("FAIL flush_resume: got v=%0b ins=%0h want 1/00f00193", out_valid_out, instr_out); end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready_in = 1'b0;
    drive(1'b1, 32'h0050_0093, 2'b00);
    step();
    drive(1'b1, 32'hFFFF_FFFF, 2'b00);
    step();
    drive(1'b0, 32'h0, 2'b00);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    total++; if (out_valid_out !== 1'b0 || in_ready_out !== 1'b1 || illegal_count_out !== 16'd0) begin bad++; $display("FAIL reset_mid: got v=%0b r=%0b c=%0d want 0/1/0", out_valid_out, in_ready_out, illegal_count_out); end
    out_ready_in = 1'b1;
    step();
    total++; if (out_valid_out !== 1'b0) begin bad++; $display("FAIL reset_mid_no_output: got %0b want 0", out_valid_out); end
  endtask

  task automatic test_illegal_mext();
    do_reset();
    out_ready_in = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 2'b00);
    step();
    total++; if (illegal_instr_out !== 1'b1 || illegal_count_out !== 16'd1) begin bad++; $display("FAIL ill_ones: got i=%0b c=%0d want 1/1", illegal_instr_out, illegal_count_out); end
    drive(1'b1, 32'h0220_8033, 2'b00);  // mul x0,x1,x2
    step();
`ifdef MSRV32_DEC_MEXT_EN
    total++; if ({illegal_instr_out, is_muldiv_out, rf_wr_en_out, alu_opcode_out, wb_mux_sel_out} !== 10'b0_1_0_0000_000 || illegal_count_out !== 16'd1) begin bad++; $display("FAIL mul_rd0: got %0b c=%0d want 0100000000 c=1", {illegal_instr_out, is_muldiv_out, rf_wr_en_out, alu_opcode_out, wb_mux_sel_out}, illegal_count_out); end
`else
    total++; if ({illegal_instr_out, is_muldiv_out, rf_wr_en_out} !== 3'b1_0_0 || illegal_count_out !== 16'd2) begin bad++; $display("FAIL mul_rd0: got %0b c=%0d want 100 c=2", {illegal_instr_out, is_muldiv_out, rf_wr_en_out}, illegal_count_out); end
`endif
    drive(1'b1, 32'h0220_D0B3, 2'b00);  // divu x1,x1,x2
    step();
    drive(1'b0, 32'h0, 2'b00);
`ifdef MSRV32_DEC_MEXT_EN
    total++; if ({illegal_instr_out, is_muldiv_out, rf_wr_en_out, alu_opcode_out} !== 7'b0_1_1_0101 || illegal_count_out !== 16'd1) begin bad++; $display("FAIL divu_rd1: got %0b c=%0d want 0110101 c=1", {illegal_instr_out, is_muldiv_out, rf_wr_en_out, alu_opcode_out}, illegal_count_out); end
`else
    total++; if ({illegal_instr_out, is_muldiv_out, rf_wr_en_out, alu_opcode_out} !== 7'b1_0_0_0101 || illegal_count_out !== 16'd3) begin bad++; $display("FAIL divu_rd1: got %0b c=%0d want 1000101 c=3", {illegal_instr_out, is_muldiv_out, rf_wr_en_out, alu_opcode_out}, illegal_count_out); end
`endif
    step();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_b;
    do_reset();
    out_ready_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 32'hFFFF_FFFF, 2'b00);
      step();
      exp_b = (k >= 3) ? 2'd3 : 2'(k);
      total++; if (b_count !== exp_b || illegal_count_out !== 16'(k)) begin bad++; $display("FAIL sat_%0d: got small=%0d wide=%0d want %0d/%0d", k, b_count, illegal_count_out, exp_b, k); end
    end
    drive(1'b0, 32'h0, 2'b00);
    step();
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst_in               = 1'b1;
    in_valid_in          = 1'b0;
    instr_in             = 32'h0;
    pc_in                = '0;
    iadder_out_1_to_0_in = 2'b00;
    trap_taken_in        = 1'b0;
    out_ready_in         = 1'b0;
    test_reset();
    test_addi();
    test_decode_table();
    test_back_to_back();
    test_misaligned();
    test_flush();
    test_reset_mid();
    test_illegal_mext();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
